// File: rtl/unified_issue_queue.sv
// unified_issue_queue: out-of-order issue queue between rename/dispatch and the
// execution units. Ops wait until both sources are ready, capture operands from the
// CDB (including same-cycle bypass at allocation), and the oldest ready ops are
// selected through an age matrix. Optional macro UIQ_SELECTIVE_SQUASH_EN adds a
// ROB-distance based partial squash next to the full flush.
module unified_issue_queue #(
  parameter int ENTRIES = 16,
  parameter int ALLOC_W = 2,
  parameter int ISSUE_W = 2,
  parameter int CDB_W   = 2,
  parameter int PHYS_W  = 6,
  parameter int DATA_W  = 64,
  parameter int OP_W    = 8,
  parameter int ROB_W   = 6,
  localparam int CNT_W  = $clog2(ENTRIES + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ALLOC_W-1:0]             alloc_valid,
  output logic [ALLOC_W-1:0]             alloc_ready,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0] alloc_dst_tag,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0] alloc_src1_tag,
  input  logic [ALLOC_W-1:0][PHYS_W-1:0] alloc_src2_tag,
  input  logic [ALLOC_W-1:0][DATA_W-1:0] alloc_src1_val,
  input  logic [ALLOC_W-1:0][DATA_W-1:0] alloc_src2_val,
  input  logic [ALLOC_W-1:0]             alloc_src1_ready,
  input  logic [ALLOC_W-1:0]             alloc_src2_ready,
  input  logic [ALLOC_W-1:0][OP_W-1:0]   alloc_op,
  input  logic [ALLOC_W-1:0][ROB_W-1:0]  alloc_rob_tag,
  input  logic [CDB_W-1:0]               cdb_valid,
  input  logic [CDB_W-1:0][PHYS_W-1:0]   cdb_tag,
  input  logic [CDB_W-1:0][DATA_W-1:0]   cdb_value,
  output logic [ISSUE_W-1:0]             issue_valid,
  input  logic [ISSUE_W-1:0]             issue_ready,
  output logic [ISSUE_W-1:0][OP_W-1:0]   issue_op,
  output logic [ISSUE_W-1:0][PHYS_W-1:0] issue_dst_tag,
  output logic [ISSUE_W-1:0][DATA_W-1:0] issue_src1_val,
  output logic [ISSUE_W-1:0][DATA_W-1:0] issue_src2_val,
  output logic [ISSUE_W-1:0][ROB_W-1:0]  issue_rob_tag,
  input  logic                           flush,
`ifdef UIQ_SELECTIVE_SQUASH_EN
  input  logic                           squash_valid,
  input  logic [ROB_W-1:0]               squash_rob_tag,
  input  logic [ROB_W-1:0]               rob_head,
`endif
  output logic [CNT_W-1:0]               free_count
);

  // Control state. older_q[i][j] = 1 means entry j is older than entry i.
  logic [ENTRIES-1:0]              valid_q, valid_d;
  logic [ENTRIES-1:0][ENTRIES-1:0] older_q, older_d;
  logic [CNT_W-1:0]                free_q, free_d;

  // Payload state.
  logic [OP_W-1:0]    op_q     [ENTRIES];
  logic [PHYS_W-1:0]  dst_q    [ENTRIES];
  logic [ROB_W-1:0]   rob_q    [ENTRIES];
  logic [PHYS_W-1:0]  s1_tag_q [ENTRIES];
  logic [PHYS_W-1:0]  s2_tag_q [ENTRIES];
  logic [DATA_W-1:0]  s1_val_q [ENTRIES];
  logic [DATA_W-1:0]  s2_val_q [ENTRIES];
  logic [ENTRIES-1:0] s1_rdy_q, s2_rdy_q;

  logic                            blocked;
  logic [ALLOC_W-1:0]              alloc_fire;
  logic [ALLOC_W-1:0][ENTRIES-1:0] alloc_oh;
  logic [ENTRIES-1:0]              alloc_any;
  logic [ENTRIES-1:0]              squash_kill, cand, fire_mask;
  logic [ISSUE_W-1:0][ENTRIES-1:0] sel;
  logic [ENTRIES-1:0][DATA_W:0]    wk1, wk2;   // {hit, value} per entry source
  logic [ALLOC_W-1:0][DATA_W:0]    bp1, bp2;   // {hit, value} per allocating source

  // Returns {hit, value}; scanning downward lets the lowest matching CDB lane win.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [PHYS_W-1:0]             tag,
    input logic [CDB_W-1:0]              v,
    input logic [CDB_W-1:0][PHYS_W-1:0]  t,
    input logic [CDB_W-1:0][DATA_W-1:0]  d
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int c = CDB_W - 1; c >= 0; c--)
      if (v[c] && t[c] == tag) r = {1'b1, d[c]};
    return r;
  endfunction

  assign blocked    = reset | flush;
  assign free_count = free_q;
  assign alloc_fire = alloc_valid & alloc_ready;
  assign cand       = valid_q & s1_rdy_q & s2_rdy_q & ~squash_kill;

  // Lane l is offered a slot only while more than l entries are free.
  always_comb begin
    for (int l = 0; l < ALLOC_W; l++)
      alloc_ready[l] = !blocked && (int'(free_q) > l);
  end

  // Accepted lanes take the lowest-index free slots, in lane order.
  always_comb begin
    int lane;
    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch behind.
    lane      = 0;
    alloc_oh  = '0;
    alloc_any = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (!valid_q[e]) begin
        for (int l = 0; l < ALLOC_W; l++)
          if (l == lane && alloc_fire[l]) alloc_oh[l][e] = 1'b1;
        lane++;
      end
    end
    for (int l = 0; l < ALLOC_W; l++) alloc_any |= alloc_oh[l];
  end

`ifdef UIQ_SELECTIVE_SQUASH_EN
  // Kill every entry at or beyond the squash point, measured as distance from the ROB head.
  always_comb begin
    logic [ROB_W-1:0] lim, dist;
    lim         = squash_rob_tag - rob_head;
    squash_kill = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      dist           = rob_q[e] - rob_head;
      squash_kill[e] = squash_valid && valid_q[e] && (dist >= lim);
    end
  end
`else
  assign squash_kill = '0;
`endif

  // Age-matrix select: each port takes the oldest candidate not already taken by a lower port.
  always_comb begin
    logic [ENTRIES-1:0] avail;
    avail = blocked ? '0 : cand;
    for (int p = 0; p < ISSUE_W; p++) begin
      sel[p] = '0;
      for (int i = 0; i < ENTRIES; i++)
        if (avail[i] && ((avail & older_q[i]) == '0)) sel[p][i] = 1'b1;
      avail          = avail & ~sel[p];
      issue_valid[p] = |sel[p];
    end
  end

  // Issue fields are a one-hot OR-mux of the selected slot, so an idle port reads all zeros.
  always_comb begin
    fire_mask      = '0;
    issue_op       = '0;
    issue_dst_tag  = '0;
    issue_src1_val = '0;
    issue_src2_val = '0;
    issue_rob_tag  = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      if (issue_ready[p]) fire_mask |= sel[p];
      for (int i = 0; i < ENTRIES; i++) begin
        if (sel[p][i]) begin
          issue_op[p]       |= op_q[i];
          issue_dst_tag[p]  |= dst_q[i];
          issue_src1_val[p] |= s1_val_q[i];
          issue_src2_val[p] |= s2_val_q[i];
          issue_rob_tag[p]  |= rob_q[i];
        end
      end
    end
  end

  // CDB matches for resident sources (wakeup) and allocating sources (bypass).
  always_comb begin
    for (int e = 0; e < ENTRIES; e++) begin
      wk1[e] = cdb_lookup(s1_tag_q[e], cdb_valid, cdb_tag, cdb_value);
      wk2[e] = cdb_lookup(s2_tag_q[e], cdb_valid, cdb_tag, cdb_value);
    end
    for (int l = 0; l < ALLOC_W; l++) begin
      bp1[l] = cdb_lookup(alloc_src1_tag[l], cdb_valid, cdb_tag, cdb_value);
      bp2[l] = cdb_lookup(alloc_src2_tag[l], cdb_valid, cdb_tag, cdb_value);
    end
  end

  // Next valid vector, age matrix and free count; a new entry is younger than all
  // survivors and than lower lanes allocated in the same cycle.
  always_comb begin
    logic [ENTRIES-1:0] survive, row;
    survive = valid_q & ~fire_mask & ~squash_kill;
    valid_d = survive | alloc_any;
    older_d = older_q;
    for (int e = 0; e < ENTRIES; e++)
      if (alloc_any[e])
        for (int k = 0; k < ENTRIES; k++) older_d[k][e] = 1'b0;
    row = survive;
    for (int l = 0; l < ALLOC_W; l++) begin
      for (int e = 0; e < ENTRIES; e++)
        if (alloc_oh[l][e]) older_d[e] = row;
      row = row | alloc_oh[l];
    end
    if (blocked) begin
      valid_d = '0;
      older_d = '0;
    end
    free_d = '0;
    for (int e = 0; e < ENTRIES; e++)
      if (!valid_d[e]) free_d = free_d + CNT_W'(1);
  end

  // Control registers; flush reaches them through the next-state logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      older_q <= '0;
      free_q  <= CNT_W'(ENTRIES);
    end else begin
      valid_q <= valid_d;
      older_q <= older_d;
      free_q  <= free_d;
    end
  end

  // Payload capture at allocation (with CDB bypass) and operand wakeup for resident entries.
  // NOTE: payload arrays carry no reset; valid_q alone decides whether a slot's contents mean anything.
  always_ff @(posedge clk) begin
    for (int e = 0; e < ENTRIES; e++) begin
      for (int l = 0; l < ALLOC_W; l++) begin
        if (alloc_oh[l][e]) begin
          op_q[e]     <= alloc_op[l];
          dst_q[e]    <= alloc_dst_tag[l];
          rob_q[e]    <= alloc_rob_tag[l];
          s1_tag_q[e] <= alloc_src1_tag[l];
          s2_tag_q[e] <= alloc_src2_tag[l];
          s1_rdy_q[e] <= alloc_src1_ready[l] | bp1[l][DATA_W];
          s2_rdy_q[e] <= alloc_src2_ready[l] | bp2[l][DATA_W];
          s1_val_q[e] <= (!alloc_src1_ready[l] && bp1[l][DATA_W]) ? bp1[l][DATA_W-1:0] : alloc_src1_val[l];
          s2_val_q[e] <= (!alloc_src2_ready[l] && bp2[l][DATA_W]) ? bp2[l][DATA_W-1:0] : alloc_src2_val[l];
        end
      end
      if (!alloc_any[e] && valid_q[e]) begin
        if (!s1_rdy_q[e] && wk1[e][DATA_W]) begin
          s1_rdy_q[e] <= 1'b1;
          s1_val_q[e] <= wk1[e][DATA_W-1:0];
        end
        if (!s2_rdy_q[e] && wk2[e][DATA_W]) begin
          s2_rdy_q[e] <= 1'b1;
          s2_val_q[e] <= wk2[e][DATA_W-1:0];
        end
      end
    end
  end

endmodule
